ieee_demo: RTL and testbench
============================

# ieee_demo

8-bit synchronous counter block packaged as a standard user project tile. It counts clock cycles while enabled on the dedicated inputs and presents the count on the dedicated outputs. It also supports synchronous clear and parallel load from the bidirectional pins, which are configured as inputs. Up/down counting is available as a compile-time option.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears the counter immediately.
- ena  input  1  tile-select indication; ignored by the logic.
- ui_in  input  8  control inputs:
  - [0] count enable.
  - [1] direction, 1 = down; used only with IEEE_DEMO_UPDOWN_EN.
  - [2] synchronous clear.
  - [3] synchronous load.
  - [7:4] unused.
- uo_out  output  8  current counter value, driven directly from the register.
- uio_in  input  8  parallel load value.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00; all bidirectional pins are inputs.

## Operation
- State: one 8-bit register `count`. There is no other state.
- Per rising edge of clk, first matching rule applies:
  1. ui_in[2]=1 → count ← 0.
  2. ui_in[3]=1 → count ← uio_in.
  3. ui_in[0]=1 → count ← count+1 (or count−1 when down-counting is enabled and selected).
  4. otherwise count holds.
- Arithmetic is modulo 256:
  - Up-counting wraps 255 → 0.
  - Down-counting wraps 0 → 255.
  - No carry or overflow output.
- The load value is the uio_in value sampled at that same edge.
- Unused inputs (ui_in[7:4], ena) have no effect.

## Timing
- Reset: while rst=1, count=0, uo_out=0, uio_out=0, uio_oe=0, independent of clk. Deassertion takes effect at the next rising edge; the first update can occur at that edge.
- Reset asserted mid-count forces 0 asynchronously; the count does not resume from the previous value.
- Latency:
  - uo_out reflects the register with no combinational path from ui_in or uio_in.
  - A change on ui_in is seen at the next rising edge.
  - uo_out updates just after that edge.
- Enable high for N edges from 0 gives uo_out=N mod 256. Enable low holds the value indefinitely.
- Clear and load asserted together: clear wins. Clear or load together with enable: clear/load wins, and no increment occurs that cycle.

## Configuration
- Macro: IEEE_DEMO_UPDOWN_EN.
- Defined:
  - ui_in[1]=1 with enable decrements, wrapping 0 → 255.
  - ui_in[1]=0 increments.
- Undefined:
  - ui_in[1] is ignored and the counter only increments.
  - RTL still declares the full ui_in port.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then rst=0 with ui_in=0 for 5 edges → uo_out=0 throughout; uio_out=0 and uio_oe=0.
- Enable/disable: ui_in[0]=1 for 10 edges → uo_out steps 1..10. ui_in[0]=0 for 5 edges → holds 10. Re-enable for 256 edges → passes 255 → 0 and ends at 10.
- Clear/load priority:
  - uio_in=8'hA5, ui_in[3]=1 for one edge → uo_out=0xA5.
  - ui_in[3]=1 and ui_in[2]=1 together → uo_out=0.
  - ui_in[3]=1 with ui_in[0]=1 → load value, no increment.
- Async reset mid-count: at count=0x37, pulse rst between edges → uo_out=0 before the next edge; counting resumes at 1 after release.
- With IEEE_DEMO_UPDOWN_EN: from 2 with ui_in[1:0]=2'b11 for 4 edges → 1, 0, 255, 254. Without the macro, the same stimulus → 3, 4, 5, 6.

Source files
------------

// File: rtl/ieee_demo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ieee_demo_if                                         |
// | Description : Pin bundle of the ieee_demo user tile: dedicated     |
// |               inputs/outputs, bidirectional pins and tile select.  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface ieee_demo_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Harness side: drives the tile inputs, observes its outputs.
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // Tile side: the counter itself.
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface : ieee_demo_if
`default_nettype wire

// File: rtl/ieee_demo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : ieee_demo                                            |
// | Description : 8-bit cycle counter user tile. ui_in[0] enables      |
// |               counting, ui_in[2] clears, ui_in[3] loads uio_in.    |
// |               Clear beats load, load beats count. The count is     |
// |               driven straight from the register onto uo_out. The  |
// |               bidirectional pins are permanently inputs.           |
// | Options     : IEEE_DEMO_UPDOWN_EN - when defined, ui_in[1]=1       |
// |               makes an enabled count step down instead of up.      |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module ieee_demo (
  input  logic             clk,
  input  logic             rst,
  ieee_demo_if.slave       bus
);

  localparam logic [7:0] C_STEP_UP   = 8'h01;
  localparam logic [7:0] C_STEP_DOWN = 8'hFF;  // +255 == -1 modulo 256

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [7:0] w_step;

  logic w_enable;
  logic w_clear;
  logic w_load;

  assign w_enable = bus.ui_in[0];
  assign w_clear  = bus.ui_in[2];
  assign w_load   = bus.ui_in[3];

`ifdef IEEE_DEMO_UPDOWN_EN
  // Direction bit selects the signed step; the adder wraps naturally.
  assign w_step = bus.ui_in[1] ? C_STEP_DOWN : C_STEP_UP;

  // Tile select and upper control bits carry no function.
  logic [4:0] w_unused_bits;
  assign w_unused_bits = {bus.ena, bus.ui_in[7:4]};
`else
  // Up-only build: direction bit is deliberately ignored.
  assign w_step = C_STEP_UP;

  logic [5:0] w_unused_bits;
  assign w_unused_bits = {bus.ena, bus.ui_in[7:4], bus.ui_in[1]};
  logic [7:0] w_unused_down;
  assign w_unused_down = C_STEP_DOWN;
`endif

  // Next-count selection in priority order: clear, load, count, hold.
  always_comb begin
    count_d = count_q;
    if (w_clear) begin
      count_d = 8'h00;
    end else if (w_load) begin
      count_d = bus.uio_in;
    end else if (w_enable) begin
      count_d = count_q + w_step;
    end
  end

  // Counter register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.uo_out  = count_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule : ieee_demo
`default_nettype wire

// File: tb/tb_ieee_demo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_ieee_demo                                         |
// | Description : Self-checking bench for ieee_demo against a          |
// |               rule-level model of the counter.                     |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_ieee_demo;

  logic clk;
  logic rst;
  ieee_demo_if u_if ();

  ieee_demo dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int model;   // expected counter value, kept as plain integer 0..255

`ifdef IEEE_DEMO_UPDOWN_EN
  localparam bit C_UPDOWN = 1'b1;
`else
  localparam bit C_UPDOWN = 1'b0;
`endif

  // Counter rules evaluated on integers: first matching rule applies.
  function automatic int next_value(int cur, logic [7:0] ui, logic [7:0] ld);
    if (ui[2])                    return 0;
    if (ui[3])                    return int'(ld);
    if (ui[0] && C_UPDOWN && ui[1]) return (cur + 255) % 256;
    if (ui[0])                    return (cur + 1) % 256;
    return cur;
  endfunction

  // Apply current inputs for one rising edge, advance model, check output.
  task automatic tick(input string name);
    model = next_value(model, u_if.ui_in, u_if.uio_in);
    @(posedge clk);
    #1;
    checks++;
    if (u_if.uo_out !== 8'(model)) begin
      errors++;
      $display("FAIL %s: uo_out=%0d expected=%0d", name, u_if.uo_out, model);
    end
  endtask

  task automatic set_inputs(input logic [7:0] ui, input logic [7:0] ld);
    u_if.ui_in  = ui;
    u_if.uio_in = ld;
    u_if.ena    = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_inputs(8'h01, 8'h5A);
    model = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (u_if.uo_out !== 8'h00 || u_if.uio_out !== 8'h00 || u_if.uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold: uo_out=%0h uio_out=%0h uio_oe=%0h expected all 0",
                 u_if.uo_out, u_if.uio_out, u_if.uio_oe);
      end
    end
    rst = 1'b0;
    set_inputs(8'h00, 8'hFF);
    repeat (5) begin
      tick("reset_idle");
      checks++;
      if (u_if.uio_out !== 8'h00 || u_if.uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL uio_const: uio_out=%0h uio_oe=%0h expected 0 0",
                 u_if.uio_out, u_if.uio_oe);
      end
    end
  endtask

  task automatic test_enable;
    set_inputs(8'h01, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      tick("enable_step");
      checks++;
      if (u_if.uo_out !== 8'(i)) begin
        errors++;
        $display("FAIL enable_seq: uo_out=%0d expected=%0d", u_if.uo_out, i);
      end
    end
    set_inputs(8'hF0, 8'h33);  // enable low, unused bits high
    repeat (5) tick("hold");
    checks++;
    if (u_if.uo_out !== 8'd10) begin
      errors++;
      $display("FAIL hold_value: uo_out=%0d expected=10", u_if.uo_out);
    end
  endtask

  task automatic test_wrap;
    bit saw_zero;
    saw_zero = 1'b0;
    set_inputs(8'h01, 8'h00);
    for (int i = 0; i < 256; i++) begin
      tick("wrap_step");
      if (u_if.uo_out === 8'h00) saw_zero = 1'b1;
    end
    checks++;
    if (!saw_zero || u_if.uo_out !== 8'd10) begin
      errors++;
      $display("FAIL wrap_256: uo_out=%0d saw_zero=%0d expected 10 and 1",
               u_if.uo_out, saw_zero);
    end
  endtask

  task automatic test_priority;
    set_inputs(8'h08, 8'hA5);
    tick("load");
    checks++;
    if (u_if.uo_out !== 8'hA5) begin
      errors++;
      $display("FAIL load_a5: uo_out=%0h expected=a5", u_if.uo_out);
    end
    set_inputs(8'h0C, 8'h77);
    tick("clear_beats_load");
    checks++;
    if (u_if.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_over_load: uo_out=%0h expected=00", u_if.uo_out);
    end
    set_inputs(8'h09, 8'h3C);
    tick("load_beats_enable");
    checks++;
    if (u_if.uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL load_no_inc: uo_out=%0h expected=3c", u_if.uo_out);
    end
    set_inputs(8'h05, 8'h00);
    tick("clear_beats_enable");
  endtask

  task automatic test_async_reset;
    set_inputs(8'h08, 8'h37);
    tick("load_37");
    set_inputs(8'h01, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    model = 0;
    checks++;
    if (u_if.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: uo_out=%0h expected=00 before edge", u_if.uo_out);
    end
    #1;
    rst = 1'b0;
    tick("resume_after_reset");
    checks++;
    if (u_if.uo_out !== 8'h01) begin
      errors++;
      $display("FAIL resume_one: uo_out=%0h expected=01", u_if.uo_out);
    end
  endtask

  task automatic test_direction;
    int exp_seq [4];
    if (C_UPDOWN) exp_seq = '{1, 0, 255, 254};
    else          exp_seq = '{3, 4, 5, 6};
    set_inputs(8'h08, 8'h02);
    tick("load_2");
    set_inputs(8'h03, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick("direction_step");
      checks++;
      if (u_if.uo_out !== 8'(exp_seq[i])) begin
        errors++;
        $display("FAIL direction_seq[%0d]: uo_out=%0d expected=%0d",
                 i, u_if.uo_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] ui;
    for (int i = 0; i < 400; i++) begin
      ui = 8'($urandom);
      // Keep clear/load rarer so long count runs and wraps occur.
      ui[2] = ($urandom_range(0, 15) == 0);
      ui[3] = ($urandom_range(0, 7) == 0);
      set_inputs(ui, 8'($urandom));
      tick("random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = 0;
    rst    = 1'b1;
    u_if.ena    = 1'b0;
    u_if.ui_in  = 8'h00;
    u_if.uio_in = 8'h00;
    test_reset();
    test_enable();
    test_wrap();
    test_priority();
    test_async_reset();
    test_direction();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ieee_demo
`default_nettype wire
